// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared constants and types for the load/store unit:
//     lsu_size_e    - access size encodings carried on req_size
//     lsu_state_e   - control FSM states
//     MEM_LAST_ADDR - highest legal byte address of the 64 KiB memory
//     byte_count()  - number of bytes touched by an access of a given size
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    localparam logic [15:0] MEM_LAST_ADDR = 16'hFFFF;

    // The illegal size reports a full word so the range check never
    // underflows; that size is rejected on its own anyway.
    function automatic logic [2:0] byte_count(input lsu_size_e size);
        case (size)
            SIZE_BYTE: byte_count = 3'd1;
            SIZE_HALF: byte_count = 3'd2;
            default:   byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the requester handshake, the response channel and the memory port
//   of the load/store unit.
//     slave  - the load/store unit's view (takes requests, drives memory)
//     master - the environment's view (requester plus memory model)
// -----------------------------------------------------------------------------
interface load_store_unit_if;

    // request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // memory port (big-endian, combinational read)
    logic [31:0] mem_adr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_adr, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_adr, mem_write, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational data alignment for the big-endian memory word.
//   The addressed byte always sits in bits [31:24] of the word read at the
//   request address, so no address-dependent shifting is needed.
//     size        - access size
//     is_unsigned - zero-extend (1) or sign-extend (0) sub-word loads
//     rword       - word captured from memory at the request address
//     wdata       - right-aligned store data
//     merged      - word to write back for a store
//     load_data   - extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        merged    = wdata;
        load_data = rword;
        case (size)
            SIZE_BYTE: begin
                merged    = {wdata[7:0], rword[23:0]};
                load_data = {{24{rword[31] & ~is_unsigned}}, rword[31:24]};
            end
            SIZE_HALF: begin
                merged    = {wdata[15:0], rword[15:0]};
                load_data = {{16{rword[31] & ~is_unsigned}}, rword[31:16]};
            end
            default: begin
                merged    = wdata;
                load_data = rword;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequences byte/half/word loads and stores to a 64 KiB big-endian memory.
//   Sub-word stores are read-modify-write (READ then WRITE); word stores go
//   straight to WRITE; loads do one READ. Illegal requests answer with an
//   error response and never touch memory.
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - request, response and memory signals (slave modport)
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    lsu_size_e   size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    lsu_size_e   req_size;
    logic [32:0] req_last_byte;
    logic        req_err;
    logic [31:0] merged;
    logic [31:0] load_data;

    // Request legality, evaluated on the raw inputs at acceptance. The last
    // touched byte is computed one bit wider so addresses near 2^32 cannot
    // wrap back into range.
    always_comb begin
        req_size      = lsu_size_e'(bus.req_size);
        req_last_byte = {1'b0, bus.req_addr} + 33'(byte_count(req_size)) - 33'd1;
        req_err       = (req_size == SIZE_BAD)
                      | ((req_size == SIZE_HALF) & bus.req_addr[0])
                      | ((req_size == SIZE_WORD) & (bus.req_addr[1:0] != 2'b00))
                      | (req_last_byte > {17'd0, MEM_LAST_ADDR});
    end

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rword       (data_q),
        .wdata       (wdata_q),
        .merged      (merged),
        .load_data   (load_data)
    );

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high exactly in IDLE, so valid alone accepts.
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    size_d     = req_size;
                    unsigned_d = bus.req_unsigned;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    err_d      = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (bus.req_write && (req_size == SIZE_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                data_d  = bus.mem_rdata;
                state_d = write_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so an asynchronous reset
    // removes mem_write and the response immediately.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_err   = (state_q == ST_RESP) && err_q;
        bus.resp_rdata = '0;
        if ((state_q == ST_RESP) && !err_q && !write_q) begin
            bus.resp_rdata = load_data;
        end
        bus.mem_adr    = addr_q;
        bus.mem_write  = (state_q == ST_WRITE);
        bus.mem_wdata  = (state_q == ST_WRITE) ? merged : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples its
            // pre-edge value regardless of statement order.
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a byte-addressed big-endian
//   memory model. Each scenario task drives stimulus and compares inline
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- memory model ----------------
    logic [7:0]  mem [0:65535];
    logic        pre_we   = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [31:0] pre_data = 32'd0;
    int          wr_pulses = 0;
    logic [15:0] ra;

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_adr[15:0]]         <= bus.mem_wdata[31:24];
            mem[bus.mem_adr[15:0] + 16'd1] <= bus.mem_wdata[23:16];
            mem[bus.mem_adr[15:0] + 16'd2] <= bus.mem_wdata[15:8];
            mem[bus.mem_adr[15:0] + 16'd3] <= bus.mem_wdata[7:0];
            wr_pulses <= wr_pulses + 1;
        end else if (pre_we) begin
            mem[pre_addr]         <= pre_data[31:24];
            mem[pre_addr + 16'd1] <= pre_data[23:16];
            mem[pre_addr + 16'd2] <= pre_data[15:8];
            mem[pre_addr + 16'd3] <= pre_data[7:0];
        end
    end

    always_comb begin
        ra = bus.mem_adr[15:0];
        bus.mem_rdata = {mem[ra], mem[ra + 16'd1], mem[ra + 16'd2], mem[ra + 16'd3]};
    end

    function automatic logic [31:0] peek(input logic [15:0] a);
        return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
    endfunction

    // Backdoor preload; only used while the DUT is idle.
    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // ---------------- request helpers ----------------
    task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Counts negedges after the acceptance edge until resp_valid (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 8);
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic err, output logic [31:0] rd);
        send(w, sz, uns, a, wd);
        wait_resp(lat);
        err = bus.resp_err;
        rd  = bus.resp_rdata;
        finish_resp();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got=%b want=0", bus.resp_err); end
        n_cmp++; if (bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_resp_rdata got=%h want=0", bus.resp_rdata); end
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got=%b want=0", bus.mem_write); end
        n_cmp++; if (bus.mem_adr !== 32'd0) begin n_bad++; $display("FAIL reset_mem_adr got=%h want=0", bus.mem_adr); end
        n_cmp++; if (bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_mem_wdata got=%h want=0", bus.mem_wdata); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_req_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_load_byte();
        int lat; logic err; logic [31:0] rd;
        poke(16'h0010, 32'h8A12_3456);
        poke(16'h0014, 32'h0000_0000);
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ldb_latency got=%0d want=2", lat); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ldb_err got=%b want=0", err); end
        n_cmp++; if (rd !== 32'hFFFF_FF8A) begin n_bad++; $display("FAIL ldb_rdata got=%h want=ffffff8a", rd); end
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (rd !== 32'h0000_008A) begin n_bad++; $display("FAIL ldbu_rdata got=%h want=0000008a", rd); end
    endtask

    task automatic test_store_half();
        int p0; int lat; logic err; logic [31:0] rd;
        p0 = wr_pulses;
        send(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_BEEF);
        @(negedge clk); // READ
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL sth_read_mem_write got=%b want=0", bus.mem_write); end
        n_cmp++; if (bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL sth_read_mem_wdata got=%h want=0", bus.mem_wdata); end
        @(negedge clk); // WRITE
        n_cmp++; if (bus.mem_write !== 1'b1) begin n_bad++; $display("FAIL sth_write_mem_write got=%b want=1", bus.mem_write); end
        n_cmp++; if (bus.mem_wdata !== 32'hBEEF_3456) begin n_bad++; $display("FAIL sth_mem_wdata got=%h want=beef3456", bus.mem_wdata); end
        n_cmp++; if (bus.mem_adr !== 32'h0000_0010) begin n_bad++; $display("FAIL sth_mem_adr got=%h want=00000010", bus.mem_adr); end
        @(negedge clk); // RESP, 3 cycles after acceptance
        n_cmp++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL sth_resp_valid got=%b want=1", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL sth_resp got=%h/%b want=0/0", bus.resp_rdata, bus.resp_err); end
        finish_resp();
        n_cmp++; if (wr_pulses - p0 !== 1) begin n_bad++; $display("FAIL sth_write_pulses got=%0d want=1", wr_pulses - p0); end
        n_cmp++; if (peek(16'h0010) !== 32'hBEEF_3456) begin n_bad++; $display("FAIL sth_mem_word got=%h want=beef3456", peek(16'h0010)); end
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (rd !== 32'hBEEF_3456 || lat !== 2) begin n_bad++; $display("FAIL ldw_after_sth got=%h lat=%0d want=beef3456 lat=2", rd, lat); end
        // word store: no read, 2-cycle latency
        p0 = wr_pulses;
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0018, 32'h1357_9BDF, lat, err, rd);
        n_cmp++; if (lat !== 2 || err !== 1'b0) begin n_bad++; $display("FAIL stw_latency got=%0d/%b want=2/0", lat, err); end
        n_cmp++; if (peek(16'h0018) !== 32'h1357_9BDF || wr_pulses - p0 !== 1) begin n_bad++; $display("FAIL stw_mem_word got=%h pulses=%0d want=13579bdf pulses=1", peek(16'h0018), wr_pulses - p0); end
    endtask

    task automatic test_errors();
        int p0; int lat; logic err; logic [31:0] rd;
        p0 = wr_pulses;
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, lat, err, rd);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL err_stw_misalign got=lat%0d/%b/%h want=lat1/1/0", lat, err, rd); end
        n_cmp++; if (wr_pulses - p0 !== 0) begin n_bad++; $display("FAIL err_stw_no_write got=%0d want=0", wr_pulses - p0); end
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_FFFF, 32'd0, lat, err, rd);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL err_ldh_ffff got=lat%0d/%b/%h want=lat1/1/0", lat, err, rd); end
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (err !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL err_size11 got=%b/%h want=1/0", err, rd); end
        run_txn(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'd0, lat, err, rd);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_ldw_range got=%b want=1", err); end
        run_txn(1'b1, 2'b00, 1'b0, 32'h0001_0000, 32'h55, lat, err, rd);
        n_cmp++; if (err !== 1'b1 || wr_pulses - p0 !== 0) begin n_bad++; $display("FAIL err_stb_range got=%b pulses=%0d want=1 pulses=0", err, wr_pulses - p0); end
    endtask

    task automatic test_resp_hold();
        int lat;
        poke(16'hFFFC, 32'hCAFE_F00D);
        send(1'b0, 2'b10, 1'b0, 32'h0000_FFFC, 32'd0);
        wait_resp(lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hold_latency got=%0d want=2", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFE_F00D || bus.req_ready !== 1'b0 || bus.resp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d got=v%b/%h/rdy%b want=v1/cafef00d/rdy0", i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
            end
            @(negedge clk);
        end
        finish_resp();
        n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release got=v%b/rdy%b want=v0/rdy1", bus.resp_valid, bus.req_ready); end
    endtask

    task automatic test_boundary();
        int lat; logic err; logic [31:0] rd;
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_FFFF, 32'd0, lat, err, rd);
        n_cmp++; if (err !== 1'b0 || rd !== 32'h0000_000D) begin n_bad++; $display("FAIL ldbu_ffff got=%b/%h want=0/0000000d", err, rd); end
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_FFFE, 32'd0, lat, err, rd);
        n_cmp++; if (err !== 1'b0 || rd !== 32'hFFFF_F00D) begin n_bad++; $display("FAIL ldh_fffe got=%b/%h want=0/fffff00d", err, rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic err; logic [31:0] rd;
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (rd !== 32'hFFFF_BEEF || lat !== 2) begin n_bad++; $display("FAIL b2b_ldh got=%h lat=%0d want=ffffbeef lat=2", rd, lat); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1 got=%b want=1", bus.req_ready); end
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (rd !== 32'h0000_BEEF) begin n_bad++; $display("FAIL b2b_ldhu got=%h want=0000beef", rd); end
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hFFFF_FF77, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL b2b_stb got=lat%0d/%b/%h want=lat3/0/0", lat, err, rd); end
        run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'd0, lat, err, rd);
        n_cmp++; if (rd !== 32'hBEEF_3477) begin n_bad++; $display("FAIL b2b_ldw got=%h want=beef3477", rd); end
    endtask

    task automatic test_reset_in_write();
        int p0;
        poke(16'h0020, 32'h1122_3344);
        p0 = wr_pulses;
        send(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_00AA);
        @(negedge clk); // READ
        @(negedge clk); // WRITE
        n_cmp++; if (bus.mem_write !== 1'b1) begin n_bad++; $display("FAIL rstw_in_write got=%b want=1", bus.mem_write); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rstw_mem_write_drop got=%b/%h want=0/0", bus.mem_write, bus.mem_wdata); end
        n_cmp++; if (bus.mem_adr !== 32'd0) begin n_bad++; $display("FAIL rstw_mem_adr got=%h want=0", bus.mem_adr); end
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen_valid = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.resp_valid) seen_valid++;
            end
            n_cmp++; if (seen_valid !== 0) begin n_bad++; $display("FAIL rstw_no_resp got=%0d want=0", seen_valid); end
        end
        n_cmp++; if (peek(16'h0020) !== 32'h1122_3344 || wr_pulses - p0 !== 0) begin n_bad++; $display("FAIL rstw_mem_unchanged got=%h pulses=%0d want=11223344 pulses=0", peek(16'h0020), wr_pulses - p0); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstw_req_ready got=%b want=1", bus.req_ready); end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b0;

        test_reset();
        test_load_byte();
        test_store_half();
        test_errors();
        test_resp_hold();
        test_boundary();
        test_back_to_back();
        test_reset_in_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all constants come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  requester has a load/store request.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned for byte and half.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  requester takes response.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  request rejected without any memory access.
REQ-015 mem_adr  out  32  byte address to the 64 KiB big-endian instruction/data memory.
REQ-016 mem_write  out  1  memory writes 4 bytes at mem_adr..mem_adr+3 on the next rising edge.
REQ-017 mem_wdata  out  32  write word; bits [31:24] go to mem_adr.
REQ-018 mem_rdata  in  32  combinational read {M[a],M[a+1],M[a+2],M[a+3]} at mem_adr.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-020 Acceptance = req_valid & req_ready; SHALL register write, size, unsigned, addr and wdata on acceptance.
REQ-021 Error check at acceptance SHALL flag: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr+nbytes-1 > 0xFFFF.
REQ-022 Erroneous request SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL NOT assert mem_write.
REQ-023 Legal load and legal byte/half store SHALL go IDLE->READ; word store SHALL go IDLE->WRITE.
REQ-024 READ SHALL last 1 cycle and capture mem_rdata into a data register. Load: READ->RESP. Byte/half store: READ->WRITE.
REQ-025 WRITE SHALL last 1 cycle with mem_write=1, then go to RESP.
REQ-026 Write merge, with R = captured word: byte {wdata[7:0],R[23:0]}; half {wdata[15:0],R[15:0]}; word = wdata.
REQ-027 Load extraction: byte R[31:24]; half R[31:16]; word R. SHALL extend to 32 bits per req_unsigned; word ignores req_unsigned.
REQ-028 mem_adr SHALL equal the registered address in every state; 0 after reset.
REQ-029 mem_write SHALL be 1 only in WRITE; mem_wdata SHALL be 0 outside WRITE.
REQ-030 RESP SHALL hold resp_valid and the data stable until resp_ready=1, then go to IDLE.
REQ-031 resp_ready outside RESP SHALL be ignored.
REQ-032 Latency from acceptance edge to resp_valid high: load 2 cycles; word store 2 cycles; byte/half store 3 cycles; error 1 cycle.
REQ-033 A new request SHALL be accepted no earlier than the cycle after the RESP handshake; back-to-back throughput is one request per 3 or 4 cycles.

Reset
REQ-034 rst SHALL immediately force state IDLE.
REQ-035 rst SHALL force req_ready=1 while rst is low again, and resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_adr=0, mem_wdata=0.
REQ-036 Reset mid-operation SHALL drop the pending request with no response. A reset in WRITE SHALL remove mem_write before the next edge.

Structure
REQ-037 Shared package SHALL hold: size encodings; FSM state enum; MEM_LAST_ADDR=16'hFFFF; byte-count function by size.
REQ-038 Merge and extract logic SHALL live in one combinational sub-module lsu_align (inputs size, unsigned, R, wdata; outputs merged word, load data).

Verification
REQ-039 Memory word at 0x0010 = 0x8A12_3456; load byte signed at 0x0010 -> resp_rdata=0xFFFF_FF8A, resp_err=0, resp_valid 2 cycles after acceptance.
REQ-040 Same memory; store half 0xBEEF at 0x0010 -> one READ, one mem_write pulse with mem_wdata=0xBEEF_3456; a later word load reads 0xBEEF_3456.
REQ-041 Store word at 0x0002 -> resp_err=1 after 1 cycle, mem_write never asserted. Load half at 0xFFFF -> resp_err=1.
REQ-042 Load word at 0xFFFC with resp_ready held low 5 cycles -> resp_valid and data stable all 5 cycles, and req_ready=0.
REQ-043 Assert rst while in WRITE during a byte store -> mem_write drops at once, no resp_valid, memory word unchanged, req_ready=1 after release.
